// File: rtl/lcd_frame_tx_if.sv
// Request handshake between the generator/detector and the LCD serial transmitter.
// The master offers a 4-bit code plus match flag; the slave accepts it on tx_valid && tx_ready.
interface lcd_frame_tx_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] code;
  logic       match;

  modport master (
    output tx_valid,
    output code,
    output match,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  code,
    input  match,
    output tx_ready
  );
endinterface

// File: rtl/lcd_frame_tx.sv
// UART-style frame sender for the FPGA-to-Arduino LCD link.
// Frame: start, code[0..3], match, even parity, stop; each bit CLKS_PER_BIT cycles.
//
//   state    | meaning
//   S_IDLE   | line at IDLE_LEVEL, tx_ready high, waiting for a request
//   S_START  | driving the start bit (~IDLE_LEVEL)
//   S_DATA   | shifting out code[0..3] then match, bit_q = 0..4
//   S_PARITY | driving even parity over {match, code}
//   S_STOP   | driving the stop bit; done pulses on its last cycle
module lcd_frame_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit IDLE_LEVEL   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  lcd_frame_tx_if.slave    tx_if,
  output logic             txd_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [5:0]    shift_q;
  logic          txd_q;
  logic          busy_q;
  logic          done_q;

  logic accept;
  logic baud_wrap;

  assign tx_if.tx_ready = (state_q == S_IDLE) && !rst;
  assign accept         = tx_if.tx_valid && tx_if.tx_ready;
  assign baud_wrap      = (baud_q == BAUD_LAST);

  assign txd_o  = txd_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (accept) begin
            // Payload is latched with parity in the top bit so the shifter
            // presents parity right after match without extra muxing.
            shift_q <= {^{tx_if.match, tx_if.code}, tx_if.match, tx_if.code};
            txd_q   <= ~IDLE_LEVEL;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        default: begin
          baud_q <= baud_wrap ? '0 : baud_q + 1'b1;
          if ((state_q == S_STOP) && (baud_q == BAUD_PRE)) begin
            done_q <= 1'b1;
          end
          if (baud_wrap) begin
            case (state_q)
              S_START: begin
                txd_q   <= shift_q[0];
                shift_q <= {1'b0, shift_q[5:1]};
                bit_q   <= '0;
                state_q <= S_DATA;
              end
              S_DATA: begin
                txd_q   <= shift_q[0];
                shift_q <= {1'b0, shift_q[5:1]};
                if (bit_q == 3'd4) begin
                  state_q <= S_PARITY;
                end else begin
                  bit_q <= bit_q + 3'd1;
                end
              end
              S_PARITY: begin
                txd_q   <= IDLE_LEVEL;
                state_q <= S_STOP;
              end
              S_STOP: begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
              default: begin
                txd_q   <= IDLE_LEVEL;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_tx.sv
// Scoreboard bench for lcd_frame_tx at CLKS_PER_BIT=4: stimulus queues hand-computed
// frames, a line monitor captures each frame from txd and compares it against the queue.
module tb_lcd_frame_tx;

  logic clk;
  logic rst;
  logic txd_o;
  logic busy_o;
  logic done_o;

  lcd_frame_tx_if tx_if ();

  lcd_frame_tx #(
    .CLKS_PER_BIT (4),
    .IDLE_LEVEL   (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tx_if  (tx_if),
    .txd_o  (txd_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bits;   // bit 0 = start ... bit 7 = stop
    int         gap;    // required start-to-start spacing, 0 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] expand(input logic [7:0] f);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = f[i / 4];
    return r;
  endfunction

  // ---------------- monitor ----------------
  int          cyc        = 0;
  bit          mon_active = 1'b0;
  int          idx        = 0;
  int          start_cyc  = 0;
  int          prev_start = 0;
  logic [31:0] line_acc;
  logic [31:0] done_acc;
  logic [31:0] busy_acc;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      if (mon_active) begin
        check("abort_no_done", done_acc, 32'h0);
        mon_active = 1'b0;
      end
    end else begin
      if (!mon_active) begin
        if (txd_o == 1'b0) begin
          mon_active = 1'b1;
          idx        = 0;
          line_acc   = '0;
          done_acc   = '0;
          busy_acc   = '0;
          prev_start = start_cyc;
          start_cyc  = cyc;
        end else begin
          check("idle_done", {31'b0, done_o}, 32'h0);
        end
      end
      if (mon_active) begin
        line_acc[idx] = txd_o;
        done_acc[idx] = done_o;
        busy_acc[idx] = busy_o;
        idx++;
        if (idx == 32) begin
          mon_active = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", line_acc, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("frame_bits", line_acc, expand(e.bits));
            check("frame_done", done_acc, 32'h8000_0000);
            check("frame_busy", busy_acc, 32'hFFFF_FFFF);
            if (e.gap != 0) check("start_gap", start_cyc - prev_start, e.gap);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] bits, input int gap);
    exp_t e;
    e.bits = bits;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [3:0] code, input logic match);
    tx_if.code     = code;
    tx_if.match    = match;
    tx_if.tx_valid = 1'b1;
    tick();
    tx_if.tx_valid = 1'b0;
    tx_if.code     = 4'bxxxx;
    tx_if.match    = 1'bx;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy_o && n < 200) begin
      tick();
      n++;
    end
    check(nm, {31'b0, busy_o}, 32'h0);
    repeat (3) tick();
  endtask

  initial begin
    rst            = 1'b1;
    tx_if.tx_valid = 1'b0;
    tx_if.code     = 4'bxxxx;
    tx_if.match    = 1'bx;

    // reset then idle
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", {31'b0, tx_if.tx_ready}, 32'h0);
    end
    check("rst_txd", {31'b0, txd_o}, 32'h1);
    check("rst_busy", {31'b0, busy_o}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_state", {28'b0, txd_o, busy_o, done_o, tx_if.tx_ready}, 32'b1001);
    end
    tick();

    // single frame 1010/1 with rejected request while busy
    push(8'b1111_0100, 0);
    send(4'b1010, 1'b1);
    repeat (6) tick();
    tx_if.code     = 4'b1111;
    tx_if.match    = 1'b1;
    tx_if.tx_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("busy_ready", {31'b0, tx_if.tx_ready}, 32'h0);
      tick();
    end
    tx_if.tx_valid = 1'b0;
    wait_idle("idle_after_f1");

    // parity zero: 0011/0
    push(8'b1000_0110, 0);
    send(4'b0011, 1'b0);
    wait_idle("idle_after_f2");

    // match=1 with zero parity: 0001/1
    push(8'b1010_0010, 0);
    send(4'b0001, 1'b1);
    wait_idle("idle_after_f3");

    // back-to-back: three frames 0101/0, 33 cycles apart
    push(8'b1000_1010, 0);
    push(8'b1000_1010, 33);
    push(8'b1000_1010, 33);
    tx_if.code     = 4'b0101;
    tx_if.match    = 1'b0;
    tx_if.tx_valid = 1'b1;
    repeat (71) tick();
    tx_if.tx_valid = 1'b0;
    tx_if.code     = 4'bxxxx;
    wait_idle("idle_after_b2b");

    // reset during DATA bit 2, frame abandoned
    send(4'b0001, 1'b1);
    repeat (13) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_txd", {31'b0, txd_o}, 32'h1);
    check("midrst_busy", {31'b0, busy_o}, 32'h0);
    check("midrst_done", {31'b0, done_o}, 32'h0);
    check("midrst_ready", {31'b0, tx_if.tx_ready}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("postrst_idle", {28'b0, txd_o, busy_o, done_o, tx_if.tx_ready}, 32'b1001);
    tick();

    // fresh frame after reset: 0110/1
    push(8'b1110_1100, 0);
    send(4'b0110, 1'b1);
    wait_idle("idle_after_f5");

    begin
      int n = 0;
      while ((exp_q.size() != 0 || mon_active) && n < 500) begin
        tick();
        n++;
      end
    end
    check("drain", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lcd_frame_tx.md
Name: lcd_frame_tx

Overview:
- Serial transmitter for the link from the FPGA to the Arduino that drives the LCD.
- Takes the generated 4-bit sequence and the detector match flag and sends them as one UART-style frame on a single wire.
- Replaces the five parallel LCD wires: the Arduino side becomes a plain serial receiver.
- Sits after the generator/detector. One frame is sent per 3-second compare event.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal values >= 2.
- IDLE_LEVEL, 1, line level while idle and during the stop bit; start bit is its inverse.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_valid  input  1  frame request; code and match are valid while high.
- tx_ready  output  1  high when a request is accepted this cycle.
- code  input  4  generated sequence; code[0] is sent first.
- match  input  1  detector result to send with the code.
- txd  output  1  serial line to the Arduino.
- busy  output  1  high while a frame is in flight.
- done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, txd=IDLE_LEVEL, tx_ready=0 during the reset cycle and 1 after, busy=0, done=0, bit and baud counters = 0, shift register = 0.
- Frame is 8 bits, each held exactly CLKS_PER_BIT cycles:
  - start (~IDLE_LEVEL)
  - code[0], code[1], code[2], code[3]
  - match
  - parity
  - stop (IDLE_LEVEL)
- Parity is even over the 5 payload bits: parity = ^{match, code}.
- Handshake: transfer occurs when tx_valid && tx_ready at a rising edge.
  - At that edge: latch code, match and parity, and enter START.
  - txd drives the start level from the next cycle. Latency from accept edge to start bit = 1 cycle.
  - tx_ready = (state==IDLE) && !rst. Requests while busy are ignored, not queued. Inputs may change freely after acceptance.
- States:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA sends 5 bits (4 code, then match); bit counter 0..4; -> PARITY after bit 4 completes.
  - PARITY -> STOP.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It wraps to 0 at each bit boundary, and the bit/state advances on the wrap.
- busy is high in START, DATA, PARITY and STOP.
- done is high for exactly the last cycle of STOP. The next cycle is IDLE with tx_ready=1.
- Back-to-back frames: minimum one IDLE cycle between stop bit and next start bit. Total frame period is 8*CLKS_PER_BIT+1 cycles.
- txd is registered (glitch-free). It is constant within a bit.
- Reset mid-frame: at the next edge txd=IDLE_LEVEL and state=IDLE. The frame is abandoned, with no done pulse and no resumption.
- tx_valid held high continuously: a new frame starts after each IDLE cycle.
- X on code/match while tx_valid is low must not propagate.

Test Plan (CLKS_PER_BIT=4, IDLE_LEVEL=1):
- Reset then idle: rst high 3 cycles, low 10 cycles -> txd=1, busy=0, done=0, tx_ready=1 from the first cycle after reset.
- Single frame: code=4'b1010, match=1, tx_valid pulsed 1 cycle.
  - txd over 32 cycles: 0,0,1,0,1,1,1,1 (parity=1), each bit 4 cycles.
  - done pulses at cycle 32 after the accept edge; busy is high for 32 cycles.
- Parity zero: code=4'b0011, match=0 -> payload 1,1,0,0,0 and parity=0. txd: 0,1,1,0,0,0,0,1.
- Busy rejection: a second tx_valid with code=4'b1111 during frame 1 -> ignored; tx_ready=0 throughout; only frame 1 appears on txd.
- Back-to-back: tx_valid held high with code=4'b0101, match=0 -> consecutive identical frames, start bits exactly 33 cycles apart, one done per frame.
- Reset mid-frame: rst asserted during the DATA bit 2 cycle -> txd=1 on the next edge, no done pulse. A fresh frame after reset is bit-exact.
